// File: rtl/fp16_to_int32.sv
// fp16_to_int32: two-stage handshaked decoder of unsigned modified FP16 {exp,man} words into INT32.
// Define FP16_DEC_ROUND_EN to also set the midpoint of the truncated low bits on shifted words.
module fp16_to_int32 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);
    logic        s1_valid;
    logic [4:0]  s1_exp;
    logic [10:0] s1_man;
    logic        s2_load;
    logic        in_fire;
    logic        s1_legal;
    logic [31:0] shifted;
    logic [31:0] rnd;
    logic [31:0] dec_data;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign s1_legal = s1_exp >= 5'd10;
    // Shift amount wraps for illegal exponents; the result is masked below.
    assign shifted  = {21'd0, s1_man} << (s1_exp - 5'd10);
`ifdef FP16_DEC_ROUND_EN
    assign rnd      = s1_exp >= 5'd11 ? 32'd1 << (s1_exp - 5'd11) : 32'd0;
`else
    assign rnd      = 32'd0;
`endif
    assign dec_data = s1_legal ? shifted | rnd : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_exp    <= 5'd0;
            s1_man    <= 11'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_exp <= in_data[15:11];
                s1_man <= in_data[10:0];
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= dec_data;
                    out_err  <= !s1_legal;
                end
            end
            if (in_fire && in_data[15:11] < 5'd10 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fp16_to_int32.sv
// tb_fp16_to_int32: scoreboard bench for fp16_to_int32 (default and FP16_DEC_ROUND_EN builds).
module tb_fp16_to_int32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_data;
    logic [15:0] err_cnt;
    logic        in_ready2, out_valid2, out_err2;
    logic [31:0] out_data2;
    logic [1:0]  err_cnt2;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_d[$];
    logic        exp_e[$];
    int m_cnt, m_cnt2;
    bit rnd_bp = 0;
    bit held = 0;
    logic [31:0] h_data;
    logic h_err;

    always #5 clk = ~clk;

    fp16_to_int32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    fp16_to_int32 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
        .err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Value = mantissa times 2^(exp-10); rounding adds half of the lowest kept weight.
    function automatic void model(input logic [15:0] w, output logic [31:0] d, output logic e);
        int x;
        longint m, v;
        x = int'(w[15:11]);
        m = longint'(w[10:0]);
        if (x < 10) begin
            d = 32'd0;
            e = 1'b1;
        end else begin
            v = m * (longint'(1) << (x - 10));
`ifdef FP16_DEC_ROUND_EN
            if (x >= 11) v = v + (longint'(1) << (x - 11));
`endif
            d = v[31:0];
            e = 1'b0;
        end
    endfunction

    // Input side: counter model and expected-response push on each input transfer.
    always @(negedge clk) begin
        logic [31:0] d;
        logic e;
        if (!rst_n) begin
            exp_d.delete();
            exp_e.delete();
            m_cnt = 0;
            m_cnt2 = 0;
        end else begin
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("err_cnt_w2", 32'(err_cnt2), 32'(m_cnt2));
            chk("in_ready_match", 32'(in_ready2), 32'(in_ready));
            if (in_valid && in_ready) begin
                model(in_data, d, e);
                exp_d.push_back(d);
                exp_e.push_back(e);
                if (e) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    end

    // Output side: pop and compare on each output transfer; stalled outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, h_data);
                chk("hold_err", 32'(out_err), 32'(h_err));
            end
            held = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_d.size() == 0) begin
                        chk("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        chk("out_data", out_data, exp_d.pop_front());
                        chk("out_err", 32'(out_err), 32'(exp_e.pop_front()));
                    end
                end else begin
                    held = 1;
                    h_data = out_data;
                    h_err = out_err;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            out_ready = $urandom_range(0, 3) != 0;
        end
    end

    task automatic push_word(input logic [15:0] d);
        bit done;
        in_data = d;
        in_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_lat(input string name, input logic [15:0] w, input logic [31:0] want_d, input logic want_e);
        repeat (3) @(posedge clk);
        #1;
        push_word(w);
        chk({name, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, out_data, want_d);
        chk({name, "_err"}, 32'(out_err), 32'(want_e));
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_out_data"}, out_data, 32'd0);
        chk({name, "_out_err"}, 32'(out_err), 32'd0);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words [3];
        int acc;
        bit a;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 16'h0;
        out_ready = 1'b1;
        #1;
        reset_checks("rst");
        // First word is offered during reset and must be taken on the first edge after release.
        in_valid = 1'b1;
        in_data = 16'h57FF;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("first_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", out_data, 32'h0000_07FF);
        chk("first_err", 32'(out_err), 32'd0);

`ifdef FP16_DEC_ROUND_EN
        check_lat("a555", 16'hA555, 32'h0015_5600, 1'b0);
        check_lat("fc00", 16'hFC00, 32'h8010_0000, 1'b0);
        check_lat("exp11", 16'h5801, 32'h0000_0003, 1'b0);
`else
        check_lat("a555", 16'hA555, 32'h0015_5400, 1'b0);
        check_lat("fc00", 16'hFC00, 32'h8000_0000, 1'b0);
        check_lat("exp11", 16'h5801, 32'h0000_0002, 1'b0);
`endif
        check_lat("exp10", 16'h5123, 32'h0000_0123, 1'b0);
        check_lat("ill_1800", 16'h1800, 32'h0000_0000, 1'b1);
        chk("ill_cnt", 32'(err_cnt), 32'd1);
        check_lat("ill_exp9", 16'h4FFF, 32'h0000_0000, 1'b1);

        // Saturation of the narrow counter from a fresh reset.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("rst2");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            push_word(16'h1800);
            chk("sat_cnt2", 32'(err_cnt2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            chk("sat_cnt16", 32'(err_cnt), 32'(i + 1));
        end

        // Back-to-back stream into a stalled output.
        repeat (4) @(posedge clk);
        #1;
        words[0] = 16'h57FF;
        words[1] = 16'hA555;
        words[2] = 16'hFC00;
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        in_data = words[0];
        for (int c = 0; c < 7; c++) begin
            if (c == 4) begin
                chk("stream_accepted", 32'(acc), 32'd2);
                chk("stream_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (c >= 4) chk("stream_rate", 32'(out_valid), 32'd1);
            a = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc++;
                if (acc < 3) in_data = words[acc];
                else in_valid = 1'b0;
            end
        end
        chk("stream_total", 32'(acc), 32'd3);

        // Reset while two words are in flight.
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_word(16'h1800);
        push_word(16'hA555);
        #2 rst_n = 1'b0;
        #1 reset_checks("midrst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        // Randomised traffic with random backpressure.
        @(posedge clk);
        #1;
        rnd_bp = 1;
        for (int i = 0; i < 600; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            push_word(16'($urandom));
        end
        rnd_bp = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_d.size() != 0; i++) @(posedge clk);
        chk("drain", 32'(exp_d.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp16_to_int32.md
FP16_TO_INT32 -- requirements
Module: fp16_to_int32

Interface
REQ-001 Parameter CNT_W, default 16: width of the saturating illegal-exponent counter.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data is valid this cycle.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  16  modified FP16 word {exp[15:11], man[10:0]}, unsigned, no sign bit.
REQ-007 out_valid  output  1  out_data and out_err are valid.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  32  reconstructed unsigned INT32 value.
REQ-010 out_err  output  1  word carried an illegal exponent (exp < 10).
REQ-011 err_cnt  output  CNT_W  count of accepted words with an illegal exponent.

Function
REQ-012 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-013 Datapath: two register stages. S1 captures exp/man; S2 holds the decoded result and drives out_*.
REQ-014 Latency: a word accepted in cycle N appears on out_valid in cycle N+2 when S2 is free.
REQ-015 Throughput: one word per cycle while out_ready stays high.
REQ-016 S2 load enable: !s2_valid || out_ready. S1 advances when S2 loads.
REQ-017 in_ready = !s1_valid || (S2 load enable). in_ready is purely combinational from state and out_ready.
REQ-018 While out_valid && !out_ready, out_data, out_err and out_valid hold stable. No word is lost or duplicated.
REQ-019 Decode for exp >= 10: out_data = zero-extend(man) << (exp - 10). Bits shifted past bit 31 cannot occur.
REQ-020 exp = 31 yields man in bits [31:21].
REQ-021 exp = 10 yields out_data = man, unshifted.
REQ-022 exp = 11 is decoded by the same rule, although the encoder never produces it.
REQ-023 exp < 10 is illegal: out_data = 0 and out_err = 1.
REQ-024 For any legal word, out_err = 0.
REQ-025 err_cnt increments by 1 on each input transfer carrying exp < 10.
REQ-026 err_cnt saturates at 2^CNT_W - 1 and never wraps.
REQ-027 Simultaneous input transfer, output transfer and S1->S2 move in one cycle are legal and must preserve order.

Reset
REQ-028 rst_n low asynchronously clears s1_valid, s2_valid and err_cnt.
REQ-029 While rst_n is low: out_valid = 0, out_err = 0, out_data = 0, in_ready = 1.
REQ-030 Reset mid-operation discards every in-flight word; none is emitted after release.
REQ-031 The first input transfer after reset release is accepted in the first rising edge with rst_n high.

Configuration
REQ-032 Macro FP16_DEC_ROUND_EN.
REQ-033 With FP16_DEC_ROUND_EN defined, for legal exp >= 11, out_data additionally has bit (exp - 11) set. This is the midpoint of the truncated low bits and reduces truncation bias.
REQ-034 With FP16_DEC_ROUND_EN defined, exp = 10 and illegal words are unchanged from REQ-021 and REQ-023.
REQ-035 Without FP16_DEC_ROUND_EN, out_data follows REQ-019 exactly, with truncated bits set to zero.
REQ-036 Latency and handshake are identical in both builds.

Verification
REQ-037 Reset, then in_data=0x57FF with out_ready=1 -> out_valid 2 cycles later, out_data=0x000007FF, out_err=0, in both builds.
REQ-038 in_data=0xA555 -> out_data=0x00155400 without the macro; 0x00155600 with FP16_DEC_ROUND_EN.
REQ-039 in_data=0xFC00 -> out_data=0x80000000 without the macro; 0x80100000 with FP16_DEC_ROUND_EN.
REQ-040 in_data=0x1800 -> out_data=0, out_err=1, err_cnt increments 0->1.
REQ-041 CNT_W=2 with 5 illegal words -> err_cnt reads 1, 2, 3, 3, 3.
REQ-042 Stream 0x57FF, 0xA555, 0xFC00 back-to-back with out_ready held low for 4 cycles, then high -> in_ready drops after 2 accepted words. Outputs then emerge in order, one per cycle, with no loss or duplication.
REQ-043 Assert rst_n low while 2 words are in flight -> out_valid=0 immediately; no stale word after release.
